// File: rtl/crc_req_arbiter.sv
// Round-robin arbiter that shares one serial CRC-16 frame engine among NREQ requesters,
// returning {payload, crc} (or a timeout error) to the requester that was granted.
module crc_req_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 34,
   parameter int CW      = 16,
   parameter int TIMEOUT = 80
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [DW+CW-1:0]     rsp_frame,
   output logic                 rsp_err,
   output logic                 eng_start,
   output logic [DW-1:0]        eng_data,
   input  logic                 eng_done,
   input  logic [CW-1:0]        eng_crc,
   output logic                 busy,
   output logic [1:0]           fsm_state
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   last;
   logic [IW-1:0]   winner;
   logic            found;
   logic [DW-1:0]   payload;
   logic [CW-1:0]   crc;
   logic            err;
   logic [TW-1:0]   cnt;
   logic            timed_out;

   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
      return IW'((int'(base) + k) % NREQ);
   endfunction

   // Handshake: a requester holds req[i] (and a stable payload) until gnt[i] pulses for one
   // cycle; its result comes back later as a one-cycle rsp_valid[i] pulse qualified by rsp_err.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req[rr_idx(last, k)]) begin
            found  = 1'b1;
            winner = rr_idx(last, k);
         end
      end
   end

   assign timed_out = (cnt == TW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = LOAD;
         LOAD:    state_nxt = RUN;
         RUN:     if (eng_done || timed_out) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A done on the same edge as the timeout still counts as a good result.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner   <= '0;
         last    <= IW'(NREQ - 1);
         payload <= '0;
         crc     <= '0;
         err     <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  owner   <= winner;
                  payload <= req_data[int'(winner)*DW +: DW];
               end
            end
            LOAD: cnt <= '0;
            RUN: begin
               if (eng_done) begin
                  crc <= eng_crc;
                  err <= 1'b0;
               end else if (timed_out) begin
                  crc <= '0;
                  err <= 1'b1;
               end else begin
                  cnt <= cnt + TW'(1);
               end
            end
            RESP: last <= owner;
            default: ;
         endcase
      end
   end

   always_comb begin
      gnt       = '0;
      rsp_valid = '0;
      rsp_frame = '0;
      rsp_err   = 1'b0;
      eng_start = 1'b0;
      case (state)
         LOAD: begin
            gnt[owner] = 1'b1;
            eng_start  = 1'b1;
         end
         RESP: begin
            rsp_valid[owner] = 1'b1;
            rsp_frame        = {payload, crc};
            rsp_err          = err;
         end
         default: ;
      endcase
   end

   assign busy      = (state != IDLE);
   assign eng_data  = payload;
   assign fsm_state = state;

endmodule

// File: tb/tb_crc_req_arbiter.sv
// Directed bench for crc_req_arbiter: stimulus pushes expected grants/responses into queues,
// a negedge monitor pops and compares them whenever the DUT presents gnt or rsp_valid.
module tb_crc_req_arbiter;

   localparam int NREQ    = 4;
   localparam int DW      = 34;
   localparam int CW      = 16;
   localparam int TIMEOUT = 80;
   localparam int FW      = DW + CW;
   localparam int EW      = 3 + 1 + 8 + FW;

   localparam logic [DW-1:0] P0 = 34'h0_1234_5678;
   localparam logic [DW-1:0] P1 = 34'h1_8765_4321;
   localparam logic [DW-1:0] P2 = 34'h2_DEAD_BEEF;
   localparam logic [DW-1:0] P3 = 34'h3_0F0F_F0F0;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*DW-1:0]   req_data = {P3, P2, P1, P0};
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      rsp_valid;
   logic [FW-1:0]        rsp_frame;
   logic                 rsp_err;
   logic                 eng_start;
   logic [DW-1:0]        eng_data;
   logic                 eng_done = 1'b0;
   logic [CW-1:0]        eng_crc = 16'hFFFF;
   logic                 busy;
   logic [1:0]           fsm_state;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int gnt_cyc = 0;
   int idle_cnt = 0;

   logic [EW-1:0]   exp_q[$];
   logic [NREQ-1:0] gnt_q[$];
   logic [EW-1:0]   mon_e;
   logic [NREQ-1:0] mon_g;

   crc_req_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_frame (rsp_frame),
      .rsp_err   (rsp_err),
      .eng_start (eng_start),
      .eng_data  (eng_data),
      .eng_done  (eng_done),
      .eng_crc   (eng_crc),
      .busy      (busy),
      .fsm_state (fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (gnt != '0) begin
         gnt_cyc = cyc;
         if (gnt_q.size() == 0) begin
            check("gnt_unexpected", 64'(gnt), 64'(0));
         end else begin
            mon_g = gnt_q.pop_front();
            check("gnt", 64'(gnt), 64'(mon_g));
            check("eng_start_with_gnt", 64'(eng_start), 64'(1));
         end
      end
      if (rsp_valid != '0) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'(0));
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'(1) << mon_e[FW+9 +: 3]);
            check("rsp_err", 64'(rsp_err), 64'(mon_e[FW+8]));
            check("rsp_frame", 64'(rsp_frame), 64'(mon_e[FW-1:0]));
            check("rsp_latency", 64'(cyc - gnt_cyc), 64'(mon_e[FW +: 8]));
         end
      end
      if (!busy) idle_cnt++;
   end

   // driver tasks
   task automatic push_txn(input logic [NREQ-1:0] g, input int idx, input logic err,
                           input int lat, input logic [FW-1:0] frame);
      gnt_q.push_back(g);
      exp_q.push_back({3'(idx), err, 8'(lat), frame});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic wait_gnt();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (gnt != '0) return;
      end
      tests++;
      fails++;
      $display("FAIL gnt_wait: no gnt within 300 cycles");
   endtask

   task automatic wait_rsp();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (rsp_valid != '0) return;
      end
      tests++;
      fails++;
      $display("FAIL rsp_wait: no rsp_valid within 300 cycles");
   endtask

   // Called in the gnt cycle; raises eng_done so the DUT samples it on RUN edge n.
   task automatic engine(input int n, input logic [CW-1:0] crc, input logic stray,
                         input logic [DW-1:0] pay);
      check("eng_data_load", 64'(eng_data), 64'(pay));
      eng_done = stray;
      if (stray) eng_crc = 16'h1111;
      @(posedge clk); #1;
      eng_done = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
      eng_done = 1'b1;
      eng_crc  = crc;
      @(posedge clk); #1;
      eng_done = 1'b0;
      eng_crc  = 16'hFFFF;
   endtask

   int g_prev;

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", 64'(gnt), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_frame", 64'(rsp_frame), 64'(0));
      check("rst_eng_start", 64'(eng_start), 64'(0));
      check("rst_eng_data", 64'(eng_data), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      reset = 1'b0;

      // single request, done on RUN edge 50
      push_txn(4'b0100, 2, 1'b0, 52, {P2, 16'hBEEF});
      req = 4'b0100;
      wait_gnt();
      req = '0;
      engine(50, 16'hBEEF, 1'b0, P2);

      // all four held from reset release: order 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         case (k % 4)
            0: push_txn(4'b0001, 0, 1'b0, 4, {P0, 16'hA000 + 16'(k)});
            1: push_txn(4'b0010, 1, 1'b0, 4, {P1, 16'hA000 + 16'(k)});
            2: push_txn(4'b0100, 2, 1'b0, 4, {P2, 16'hA000 + 16'(k)});
            default: push_txn(4'b1000, 3, 1'b0, 4, {P3, 16'hA000 + 16'(k)});
         endcase
      end
      req = 4'b1111;
      do_reset();
      g_prev = 0;
      for (int k = 0; k < 5; k++) begin
         wait_gnt();
         if (k == 0) idle_cnt = 0;
         else check("rr_gap", 64'(cyc - g_prev), 64'(6));
         g_prev = cyc;
         if (k == 4) begin
            check("rr_idle_cycles", 64'(idle_cnt), 64'(4));
            req = '0;
         end
         case (k % 4)
            0: engine(2, 16'hA000 + 16'(k), 1'b0, P0);
            1: engine(2, 16'hA000 + 16'(k), 1'b0, P1);
            2: engine(2, 16'hA000 + 16'(k), 1'b0, P2);
            default: engine(2, 16'hA000 + 16'(k), 1'b0, P3);
         endcase
      end

      // engine never answers: timeout, then a normal transaction
      do_reset();
      push_txn(4'b0001, 0, 1'b1, TIMEOUT + 2, {P0, 16'h0000});
      req = 4'b0001;
      wait_gnt();
      req = '0;
      wait_rsp();
      push_txn(4'b0010, 1, 1'b0, 12, {P1, 16'h1234});
      req = 4'b0010;
      wait_gnt();
      req = '0;
      engine(10, 16'h1234, 1'b0, P1);

      // stray done in IDLE and in LOAD
      do_reset();
      eng_done = 1'b1;
      @(posedge clk); #1;
      eng_done = 1'b0;
      check("stray_idle_state", 64'(fsm_state), 64'(0));
      check("stray_idle_busy", 64'(busy), 64'(0));
      push_txn(4'b1000, 3, 1'b0, 7, {P3, 16'h5A5A});
      req = 4'b1000;
      wait_gnt();
      req = '0;
      engine(5, 16'h5A5A, 1'b1, P3);

      // reset on RUN edge 20, then req=1010 pending
      do_reset();
      gnt_q.push_back(4'b0100);
      req = 4'b0100;
      wait_gnt();
      req = '0;
      repeat (21) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      req = 4'b1010;
      @(posedge clk); #1;
      check("midrst_gnt", 64'(gnt), 64'(0));
      check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("midrst_rsp_frame", 64'(rsp_frame), 64'(0));
      check("midrst_rsp_err", 64'(rsp_err), 64'(0));
      check("midrst_eng_start", 64'(eng_start), 64'(0));
      check("midrst_eng_data", 64'(eng_data), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      push_txn(4'b0010, 1, 1'b0, 5, {P1, 16'hC111});
      push_txn(4'b1000, 3, 1'b0, 5, {P3, 16'hC333});
      reset = 1'b0;
      wait_gnt();
      req = 4'b1000;
      engine(3, 16'hC111, 1'b0, P1);
      wait_gnt();
      req = '0;
      engine(3, 16'hC333, 1'b0, P3);

      // done coincident with the final timeout edge
      do_reset();
      push_txn(4'b0001, 0, 1'b0, TIMEOUT + 2, {P0, 16'hC0DE});
      req = 4'b0001;
      wait_gnt();
      req = '0;
      engine(TIMEOUT, 16'hC0DE, 1'b0, P0);

      // final report
      repeat (5) @(posedge clk);
      #1;
      check("exp_q_drained", 64'(exp_q.size()), 64'(0));
      check("gnt_q_drained", 64'(gnt_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/crc_req_arbiter.md
# crc_req_arbiter

Round-robin arbiter and sequencer that shares one serial CRC-16 frame engine among NREQ requesters. It captures the winning requester's 34-bit payload, starts the engine, and waits for completion or timeout. It then returns the 50-bit frame {payload, crc} to that requester. It sits between the per-channel payload sources and the single serial CRC engine.

## Interface
- NREQ, 4: number of requesters, 2..8
- DW, 34: payload width
- CW, 16: CRC width
- TIMEOUT, 80: maximum RUN cycles to wait for eng_done, at least 2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; held high until its gnt bit pulses
- req_data  in  NREQ*DW  payloads; requester i occupies bits [i*DW +: DW]; must be stable while req[i] is high
- gnt  out  NREQ  one-hot, one-cycle pulse: payload captured
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: rsp_frame/rsp_err are valid for that requester
- rsp_frame  out  DW+CW  {captured payload, crc}
- rsp_err  out  1  qualifies rsp_valid; 1 means timeout, and crc field is 0
- eng_start  out  1  one-cycle start pulse to the engine
- eng_data  out  DW  captured payload; held from LOAD through the end of RUN
- eng_done  in  1  engine completion pulse
- eng_crc  in  CW  engine result; sampled on the edge where eng_done=1
- busy  out  1  high in every state other than IDLE

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE: if any req bit is high, select the winner by round robin. Search starts at (last+1) mod NREQ. Capture the winner's index and payload, then go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle): gnt[owner]=1 and eng_start=1. Clear the timeout counter and go to RUN. eng_done is ignored in this state.
- RUN: on each edge, if eng_done=1, latch eng_crc, set err=0, and go to RESP. Otherwise increment the counter. If the counter reaches TIMEOUT, set the latched crc to 0, set err=1, and go to RESP.
- RESP (1 cycle): rsp_valid[owner]=1, rsp_frame={payload, crc}, rsp_err=err. Set last=owner and go to IDLE.
- eng_done in IDLE or RESP is ignored and has no side effect.
- req bits that drop before gnt are simply not selected. A requester that holds req after its own gnt is treated as a new request.
- The counter is clog2(TIMEOUT+1) bits wide and does not wrap. It saturates by leaving RUN.
- Only one transaction is ever in flight. Other requesters wait with req held high.

## Timing
- Reset values: state=IDLE, last=NREQ-1 (requester 0 wins first), gnt=0, rsp_valid=0, rsp_frame=0, rsp_err=0, eng_start=0, eng_data=0, busy=0, counter=0.
- All outputs are registered or decoded from state (Moore). No combinational path exists from req or eng_done to any output.
- Edge E0 samples req in IDLE. gnt and eng_start are high in the cycle after E0.
- If eng_done is sampled high at the N-th RUN edge (N=1..TIMEOUT), rsp_valid is high in the following cycle. rsp_valid therefore appears N+2 cycles after gnt.
- On timeout, rsp_valid with rsp_err=1 appears TIMEOUT+2 cycles after gnt.
- The minimum turnaround between rsp_valid and the next gnt is 2 cycles (IDLE, then LOAD).
- If eng_done and the timeout condition are true on the same edge, eng_done wins and err=0.
- Reset asserted in any state takes effect at the next edge:
  - any in-flight transaction is dropped with no rsp_valid;
  - the round-robin pointer returns to its reset value;
  - eng_start is not reissued.

## Test plan
- Single request, engine model returns done on the 50th RUN edge with eng_crc=16'hBEEF; req[2]=1, payload 34'h2_DEAD_BEEF -> gnt=4'b0100 and eng_start=1 together; rsp_valid=4'b0100 exactly 52 cycles after gnt; rsp_frame={34'h2_DEAD_BEEF,16'hBEEF}; rsp_err=0.
- All four req held high from reset release -> grant order 0,1,2,3,0; one rsp_valid per gnt, each to the matching requester; busy never drops between back-to-back transactions except the single IDLE cycle.
- Engine never asserts eng_done -> rsp_valid with rsp_err=1 and rsp_frame={payload,16'h0} at TIMEOUT+2=82 cycles after gnt; the FSM returns to IDLE and serves the next request normally.
- Stray eng_done pulses in IDLE and on the LOAD cycle -> no rsp_valid and no state change; the real done on RUN edge 5 gives rsp_valid 7 cycles after gnt.
- Reset asserted on RUN edge 20 -> in the next cycle all outputs are 0 and there is no rsp_valid; with req=4'b1010 pending, requester 1 is granted first after release.
- eng_done coincident with the final timeout edge (N=TIMEOUT) -> rsp_err=0 and the crc field equals eng_crc.
